// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter
//   Shares the CPU local bus between the 8088 core and NREQ DMA requesters.
//   A request raises hold to the CPU. Once hlda returns, the block waits
//   SETTLE cycles for the bus to float. It then grants one channel (one-hot
//   dack, aen high) until that channel drops its request. After that hold
//   is released, and the CPU regains the bus before any further DMA burst.
//   Every output is driven straight from a register.
//
// Ports
//   clk      in   system clock
//   rst      in   asynchronous reset, active-low
//   dreq     in   [NREQ]  per-channel request, level-sensitive
//   rot_pri  in   0 = fixed priority (ch0 highest), 1 = rotating priority
//   hlda     in   hold acknowledge from the CPU
//   hold     out  hold request to the CPU
//   dack     out  [NREQ]  one-hot grant
//   aen      out  DMA owns the bus (high exactly when dack != 0)
//   owner    out  [clog2(NREQ)]  granted channel index, 0 when idle
//   err      out  one-cycle pulse when hlda falls during SETTLE or GRANT
module dma_bus_arbiter #(
  parameter int NREQ   = 4,
  parameter int SETTLE = 2,
  localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] dreq,
  input  logic            rot_pri,
  input  logic            hlda,
  output logic            hold,
  output logic [NREQ-1:0] dack,
  output logic            aen,
  output logic [IW-1:0]   owner,
  output logic            err
);

  localparam int CW = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_SETTLE,
    ST_GRANT,
    ST_RELEASE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     last_q, last_d;
  logic              hold_q, hold_d;
  logic [NREQ-1:0]   dack_q, dack_d;
  logic              aen_q, aen_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic              err_q, err_d;

  logic              win_valid;
  logic [IW-1:0]     win_idx;
  logic              viol;
  logic              grant_now;

  // Arbitration. The scan runs from the highest search offset down to the
  // lowest. The last hit therefore belongs to the channel nearest the start
  // of the search. Rotating mode starts just after the last winner, modulo
  // NREQ, so the logic also holds for non-power-of-two channel counts.
  always_comb begin
    int base;
    int idx;
    win_valid = 1'b0;
    win_idx   = '0;
    base      = 0;
    idx       = 0;
    if (rot_pri) begin
      base = (int'(last_q) + 1) % NREQ;
    end
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (base + k) % NREQ;
      if (dreq[idx]) begin
        win_valid = 1'b1;
        win_idx   = IW'(idx);
      end
    end
  end

  // Losing hlda while the bus is (about to be) ours is a protocol violation.
  assign viol      = ((state_q == ST_SETTLE) || (state_q == ST_GRANT)) && !hlda;
  assign grant_now = (state_q == ST_SETTLE) && hlda && (cnt_q == '0) && win_valid;

  // State register. Reset drops every output in the same instant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      hold_q  <= 1'b0;
      dack_q  <= '0;
      aen_q   <= 1'b0;
      owner_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      dack_q  <= dack_d;
      aen_q   <= aen_d;
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|dreq) state_d = ST_REQ;
      end
      ST_REQ: begin
        // The hold handshake cannot be aborted. If the requests have gone
        // by the time hlda arrives, hand the bus straight back.
        if (hlda) begin
          if (|dreq) begin
            state_d = ST_SETTLE;
            cnt_d   = CW'(SETTLE - 1);
          end else begin
            state_d = ST_RELEASE;
          end
        end
      end
      ST_SETTLE: begin
        if (viol) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = win_valid ? ST_GRANT : ST_RELEASE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GRANT: begin
        // Only the owner's request matters. No preemption.
        if (viol) begin
          state_d = ST_IDLE;
        end else if (!(|(dreq & dack_q))) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!hlda) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic, computed one cycle ahead so that every pin is a flop
  always_comb begin
    hold_d  = (state_d == ST_REQ) || (state_d == ST_SETTLE) || (state_d == ST_GRANT);
    err_d   = viol;
    last_d  = last_q;
    dack_d  = '0;
    aen_d   = 1'b0;
    owner_d = '0;
    if (grant_now) begin
      dack_d[win_idx] = 1'b1;
      aen_d           = 1'b1;
      owner_d         = win_idx;
      last_d          = win_idx;
    end else if (state_d == ST_GRANT) begin
      dack_d  = dack_q;
      aen_d   = 1'b1;
      owner_d = owner_q;
    end
  end

  assign hold  = hold_q;
  assign dack  = dack_q;
  assign aen   = aen_q;
  assign owner = owner_q;
  assign err   = err_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Testbench for dma_bus_arbiter. The test runs in four parts:
//   1. Reset and table-driven vectors.
//   2. Asynchronous reset applied during a grant.
//   3. A rotating-priority sequence.
//   4. Random traffic checked against a behavioural model.
module tb_dma_bus_arbiter;

  localparam int NREQ   = 4;
  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] dreq = 4'b0;
  logic       rot_pri = 1'b0;
  logic       hlda = 1'b0;
  logic       hold;
  logic [3:0] dack;
  logic       aen;
  logic [1:0] owner;
  logic       err;

  int total = 0;
  int bad   = 0;

  dma_bus_arbiter #(.NREQ(NREQ), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .dreq(dreq), .rot_pri(rot_pri), .hlda(hlda),
    .hold(hold), .dack(dack), .aen(aen), .owner(owner), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] dreq;
    logic       hlda;
    logic       hold;
    logic [3:0] dack;
    logic       aen;
    logic [1:0] owner;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [3:0] dq, logic hl, logic ho, logic [3:0] dk,
                              logic ae, logic [1:0] ow, logic er);
    vec_t v;
    v.dreq = dq; v.hlda = hl; v.hold = ho; v.dack = dk;
    v.aen = ae; v.owner = ow; v.err = er;
    return v;
  endfunction

  // Behavioural model. It keeps the bus relationship as plain variables:
  //   m_ch   = granted channel, or -1 when there is no grant.
  //   m_seen = edges since hlda was accepted (0 = not yet accepted).
  //   m_rel  = hold has been dropped and the model waits for hlda to fall.
  bit m_hold;
  int m_ch;
  int m_seen;
  bit m_rel;
  int m_last;
  bit m_err;

  task automatic model_reset();
    m_hold = 0; m_ch = -1; m_seen = 0; m_rel = 0; m_last = NREQ - 1; m_err = 0;
  endtask

  function automatic int m_arb(logic [3:0] dq, bit rot, int last);
    int start = rot ? (last + 1) % NREQ : 0;
    for (int k = 0; k < NREQ; k++) begin
      if (dq[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] dq, input bit rot, input bit hl);
    int w;
    m_err = 0;
    if (m_rel) begin
      if (!hl) m_rel = 0;
    end else if (!m_hold) begin
      if (dq != 0) begin m_hold = 1; m_seen = 0; end
    end else if (m_ch >= 0) begin
      if (!hl) begin
        m_ch = -1; m_hold = 0; m_err = 1;
      end else if (!dq[m_ch]) begin
        m_ch = -1; m_hold = 0; m_rel = 1;
      end
    end else if (m_seen == 0) begin
      if (hl) begin
        if (dq != 0) m_seen = 1;
        else begin m_hold = 0; m_rel = 1; end
      end
    end else begin
      if (!hl) begin
        m_hold = 0; m_seen = 0; m_err = 1;
      end else if (m_seen == SETTLE) begin
        w = m_arb(dq, rot, m_last);
        m_seen = 0;
        if (w >= 0) begin m_ch = w; m_last = w; end
        else begin m_hold = 0; m_rel = 1; end
      end else begin
        m_seen++;
      end
    end
  endtask

  task automatic model_check();
    chk("rnd_hold", hold, m_hold);
    chk("rnd_dack", dack, (m_ch < 0) ? 0 : (1 << m_ch));
    chk("rnd_aen", aen, m_ch >= 0);
    chk("rnd_owner", owner, (m_ch < 0) ? 0 : m_ch);
    chk("rnd_err", err, m_err);
  endtask

  initial begin
    int ng, low, age, got;

    // Vectors: the inputs are applied before edge i, and the expected
    // outputs are read after it. rot_pri stays 0 throughout.
    vecs.push_back(mk(4'b0010, 0, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(4'b0010, 0, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(4'b0010, 1, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(4'b1010, 1, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(4'b1010, 1, 1, 4'b0010, 1, 1, 0));
    vecs.push_back(mk(4'b1010, 1, 1, 4'b0010, 1, 1, 0));
    vecs.push_back(mk(4'b1000, 1, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(4'b1000, 1, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(4'b1000, 0, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(4'b1000, 0, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(4'b1000, 1, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(4'b1000, 1, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(4'b1000, 1, 1, 4'b1000, 1, 3, 0));
    vecs.push_back(mk(4'b0000, 1, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(4'b0001, 0, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(4'b0000, 1, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(4'b0100, 0, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(4'b0100, 1, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(4'b0100, 1, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(4'b0100, 1, 1, 4'b0100, 1, 2, 0));
    vecs.push_back(mk(4'b0100, 1, 1, 4'b0100, 1, 2, 0));
    vecs.push_back(mk(4'b0100, 0, 0, 4'b0000, 0, 0, 1));
    vecs.push_back(mk(4'b0100, 0, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(4'b0000, 1, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(4'b0001, 0, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(4'b0001, 1, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(4'b0001, 1, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(4'b0001, 1, 1, 4'b0001, 1, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 0, 4'b0000, 0, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 0, 4'b0000, 0, 0, 0));

    // Reset is held while a request is pending: every output must stay low.
    dreq = 4'b0010;
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold", hold, 0);
      chk("rst_dack", dack, 0);
      chk("rst_aen", aen, 0);
      chk("rst_owner", owner, 0);
      chk("rst_err", err, 0);
    end
    rst = 1'b1;

    foreach (vecs[i]) begin
      dreq = vecs[i].dreq;
      hlda = vecs[i].hlda;
      @(negedge clk);
      chk($sformatf("vec%0d_hold", i), hold, vecs[i].hold);
      chk($sformatf("vec%0d_dack", i), dack, vecs[i].dack);
      chk($sformatf("vec%0d_aen", i), aen, vecs[i].aen);
      chk($sformatf("vec%0d_owner", i), owner, vecs[i].owner);
      chk($sformatf("vec%0d_err", i), err, vecs[i].err);
    end

    // Assert reset asynchronously while ch3 holds the bus.
    dreq = 4'b1000;
    got  = 0;
    for (int c = 0; c < 30 && got == 0; c++) begin
      if (dack == 4'b1000) got = 1;
      else begin
        hlda = hold;
        @(negedge clk);
      end
    end
    chk("arst_pre_grant", got, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_dack", dack, 0);
    chk("arst_aen", aen, 0);
    chk("arst_hold", hold, 0);
    chk("arst_owner", owner, 0);
    @(negedge clk);
    rst  = 1'b1;
    hlda = 1'b0;

    // Rotating priority with every channel requesting. The CPU echoes
    // hold, and each owner drops its request briefly after two granted
    // cycles.
    rot_pri = 1'b1;
    dreq    = 4'hF;
    ng = 0; low = 0; age = 0;
    for (int c = 0; c < 400 && ng < 5; c++) begin
      if (aen) begin
        if (age == 0) begin
          chk($sformatf("rot%0d_owner", ng), owner, ng % 4);
          chk($sformatf("rot%0d_dack", ng), dack, 4'b0001 << (ng % 4));
          if (ng > 0) chk($sformatf("rot%0d_gap", ng), low > 0, 1);
          ng++;
          low = 0;
        end
        age++;
        if (age == 2) dreq = 4'hF & ~dack;
      end else begin
        age  = 0;
        dreq = 4'hF;
        if (!hold) low++;
      end
      hlda = hold;
      @(negedge clk);
    end
    chk("rot_count", ng, 5);

    // Random traffic checked against the model.
    rst = 1'b0; dreq = 0; hlda = 0; rot_pri = 0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      model_check();
      for (int b = 0; b < NREQ; b++) begin
        if ($urandom_range(0, 9) == 0) dreq[b] = ~dreq[b];
      end
      if ($urandom_range(0, 199) == 0) rot_pri = ~rot_pri;
      if (hold && !hlda) hlda = ($urandom_range(0, 2) == 0);
      else if (!hold && hlda) hlda = ($urandom_range(0, 1) == 0);
      else if (hold && hlda && $urandom_range(0, 79) == 0) hlda = 1'b0;
      @(posedge clk);
      model_step(dreq, rot_pri, hlda);
      @(negedge clk);
    end
    model_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
